// File: rtl/mmu_sequencer.sv
// ============================================================================
// Module   : mmu_sequencer
// Purpose  : Job sequencer for the 3x3 matrix-multiply accelerator: loads W/X
//            into operand banks, runs the feed/drain schedule, unloads results.
//            Optional cycle counter enabled by MMU_SEQ_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmu_sequencer #(
    parameter int DW           = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int DIM_W        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] row_w,
    input  logic [DIM_W-1:0] col_w,
    input  logic [DIM_W-1:0] row_x,
    input  logic [DIM_W-1:0] col_x,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_clear,
    output logic             mem_we,
    output logic             mem_sel,
    output logic [3:0]       mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             feed_en,
    output logic [1:0]       feed_step,
    output logic [8:0]       mac_en,
    output logic [8:0]       mac_clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_row,
    output logic [1:0]       res_col,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef MMU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      cyc_count
`endif
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ERR    = 4'd1,
        S_CLEAR  = 4'd2,
        S_LOAD_W = 4'd3,
        S_LOAD_X = 4'd4,
        S_FEED   = 4'd5,
        S_DRAIN  = 4'd6,
        S_UNLOAD = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] row_w_q, row_w_d, col_w_q, col_w_d;
    logic [DIM_W-1:0] row_x_q, row_x_d, col_x_q, col_x_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [1:0]       res_row_q, res_row_d, res_col_q, res_col_d;
    logic             mem_we_q, mem_we_d, mem_sel_q, mem_sel_d;
    logic [3:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;

    logic [8:0]       w_mask;
    logic [3:0]       w_n_w, w_n_x;
    logic             w_dims_ok;
    logic             w_beat;
    logic             w_last_col, w_last_row;

    // Active cell mask: rows of the result are W rows, columns are X columns
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            assign w_mask[gi*3+gj] = (DIM_W'(gi) < row_w_q) && (DIM_W'(gj) < col_x_q);
        end
    end

    assign w_n_w      = 4'(row_w_q) * 4'(col_w_q);
    assign w_n_x      = 4'(row_x_q) * 4'(col_x_q);
    assign w_dims_ok  = (row_w != '0) && (col_w != '0) && (row_x != '0) &&
                        (col_x != '0) && (col_w == row_x);
    assign w_beat     = in_valid && in_ready;
    assign w_last_col = (DIM_W'(res_col_q) == col_x_q - DIM_W'(1));
    assign w_last_row = (DIM_W'(res_row_q) == row_w_q - DIM_W'(1));

    always_comb begin
        state_d     = state_q;
        row_w_d     = row_w_q;
        col_w_d     = col_w_q;
        row_x_d     = row_x_q;
        col_x_d     = col_x_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        mem_we_d    = 1'b0;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_w_d = row_w;
                    col_w_d = col_w;
                    row_x_d = row_x;
                    col_x_d = col_x;
                    state_d = w_dims_ok ? S_CLEAR : S_ERR;
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_CLEAR: begin
                cnt_d   = 4'd0;
                state_d = S_LOAD_W;
            end
            S_LOAD_W, S_LOAD_X: begin
                if (w_beat) begin
                    mem_we_d    = 1'b1;
                    mem_sel_d   = (state_q == S_LOAD_X);
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = in_data;
                    if (cnt_q == ((state_q == S_LOAD_X) ? w_n_x : w_n_w) - 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = (state_q == S_LOAD_X) ? S_FEED : S_LOAD_X;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_FEED: begin
                if (cnt_q == 4'(col_w_q) - 4'd1) begin
                    cnt_d   = 4'd0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                    res_row_d = 2'd0;
                    res_col_d = 2'd0;
                    state_d   = S_UNLOAD;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            S_UNLOAD: begin
                if (res_ready) begin
                    if (w_last_col && w_last_row) begin
                        state_d = S_DONE;
                    end else if (w_last_col) begin
                        res_col_d = 2'd0;
                        res_row_d = res_row_q + 2'd1;
                    end else begin
                        res_col_d = res_col_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                res_row_d = 2'd0;
                res_col_d = 2'd0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_w_q     <= '0;
            col_w_q     <= '0;
            row_x_q     <= '0;
            col_x_q     <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            row_w_q     <= row_w_d;
            col_w_q     <= col_w_d;
            row_x_q     <= row_x_d;
            col_x_q     <= col_x_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            mem_we_q    <= mem_we_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Accumulators stay live from FEED through the end of UNLOAD
    always_comb begin
        in_ready  = (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
        mem_clear = (state_q == S_CLEAR);
        feed_en   = (state_q == S_FEED);
        feed_step = (state_q == S_FEED) ? cnt_q[1:0] : 2'd0;
        mac_en    = ((state_q == S_FEED) || (state_q == S_DRAIN)) ? w_mask : 9'h000;
        mac_clr   = ((state_q == S_FEED) || (state_q == S_DRAIN) ||
                     (state_q == S_UNLOAD)) ? ~w_mask : 9'h1FF;
        res_valid = (state_q == S_UNLOAD);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
    end

    assign mem_we    = mem_we_q;
    assign mem_sel   = mem_sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign res_row   = res_row_q;
    assign res_col   = res_col_q;

`ifdef MMU_SEQ_PERF_CNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == S_IDLE) && start) begin
            cyc_d = 16'd0;
        end else if ((state_q != S_IDLE) && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc_count = cyc_q;
`endif

endmodule

`default_nettype wire

// File: doc/mmu_sequencer.md
Name: mmu_sequencer

Overview:
- Top-level controller for the 3x3 matrix-multiply accelerator: accepts a job (dimensions plus element stream), writes W then X into the operand memory banks, and drives the systolic-array feed schedule and MAC enables/clears.
- Waits for the array to drain, then streams results out row-major with a valid/ready handshake.
- Sits between the host interface and the operand-memory / MAC-array datapath.
- Replaces the free-running counter sequencing with an explicit resettable FSM.

Parameters:
- DW, 4, element data width (operand memory width).
- DRAIN_CYCLES, 4, cycles after the last feed step before results are valid (systolic skew plus MAC latency).
- DIM_W, 2, width of each dimension field; legal dimension values are 1..3.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job request; sampled in IDLE only.
- row_w, col_w, row_x, col_x  input  DIM_W each  matrix dimensions, captured on start accept.
- in_data  input  DW  element stream: W row-major, then X row-major.
- in_valid  input  1  in_data valid.
- in_ready  output  1  sequencer accepts in_data this cycle.
- mem_clear  output  1  clear both operand banks.
- mem_we  output  1  write strobe to operand bank.
- mem_sel  output  1  0 = W bank, 1 = X bank.
- mem_addr  output  4  write address 0..8.
- mem_wdata  output  DW  registered copy of accepted in_data.
- feed_en  output  1  operand banks present feed step to array.
- feed_step  output  2  k index of current feed step.
- mac_en  output  9  per-cell accumulate enable; cell i*3+j.
- mac_clr  output  9  per-cell accumulator clear.
- res_valid  output  1  result index valid.
- res_ready  input  1  host consumes result.
- res_row, res_col  output  2 each  result cell being presented.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse on job completion.
- err  output  1  one-cycle pulse on rejected job.

Behaviour:
- Reset: state=IDLE. All outputs 0, except mac_clr=9'h1FF. Latched dims cleared.
- IDLE:
  - start=1 captures the dims.
  - Dim check: if any dim is 0 or col_w!=row_x -> ERR; otherwise -> CLEAR.
  - start asserted outside IDLE is ignored.
- ERR: err=1 for one cycle -> IDLE. No memory or MAC activity.
- CLEAR: one cycle; mem_clear=1, mac_clr=9'h1FF -> LOAD_W.
- LOAD_W:
  - in_ready=1. Each in_valid&&in_ready beat registers mem_we=1, mem_sel=0, mem_addr=cnt, mem_wdata=in_data on the next cycle.
  - cnt is a 4-bit counter from 0. After beat number row_w*col_w (cnt reaches count-1 on a beat): cnt:=0 -> LOAD_X.
  - Gaps (in_valid=0) stall without side effects.
- LOAD_X: same rules with mem_sel=1; after row_x*col_x beats -> FEED. in_ready drops in the FEED entry cycle.
- FEED:
  - col_w cycles, feed_en=1, feed_step=0..col_w-1.
  - mac_en[i*3+j] = (i<row_w)&&(j<col_x); mac_clr is the complement of that mask.
  - After step col_w-1 -> DRAIN.
- DRAIN:
  - DRAIN_CYCLES cycles; feed_en=0, mac_en held at the mask so pipeline tails accumulate.
  - Then -> UNLOAD with mac_en=0.
- UNLOAD:
  - res_valid=1, (res_row,res_col) start at (0,0).
  - Advance row-major on res_valid&&res_ready: col wraps at col_x-1 to 0 and row increments.
  - res_row/res_col must hold stable while res_valid&&!res_ready.
  - After the handshake on (row_w-1, col_x-1) -> DONE.
- DONE: done=1 one cycle, res_valid=0, mac_clr=9'h1FF -> IDLE.
- Accumulators are never cleared between DRAIN and the end of UNLOAD.
- Element count = row*col computed as 4-bit, max 9. Feed/drain counters are saturating-free, sized to DRAIN_CYCLES.
- rst_n asserted mid-job: immediate return to reset values. The partial job is discarded; the next job must restart from start.
- Latency, start to first mem_we with in_valid held high: 3 cycles (accept, CLEAR, beat register).

Optional Feature:
- Macro MMU_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output cyc_count[15:0].
  - Cleared on start accept; increments every cycle while busy, saturating at 16'hFFFF.
  - Holds its value after DONE until the next accept.
- Undefined: cyc_count port absent; no counter logic.

Test Plan:
- 2x2 * 2x2, in_valid continuous, res_ready=1 -> 4 W beats at addr 0..3 sel=0, then 4 X beats at addr 0..3 sel=1, feed_step 0,1, mac_en=9'h01B, 4 results (0,0),(0,1),(1,0),(1,1), done pulse. With MMU_SEQ_PERF_CNT_EN: cyc_count = 1+8+2+4+4+1 = 20 ±1 per the documented counting edge.
- 3x3 * 3x3 with in_valid low every other cycle, res_ready toggling -> 9+9 writes in order, no duplicate beats, mac_en=9'h1FF, 9 results with indices stable during stalls.
- 1x3 * 3x2 -> 3 W and 6 X writes, feed_step 0..2, mac_en=9'h003, results (0,0),(0,1).
- col_w=2,row_x=3 or row_w=0 -> err pulse one cycle after start, no mem_we/mem_clear, busy low again.
- rst_n low during LOAD_X, then a new 1x1*1x1 job -> all outputs at reset values asynchronously; the new job completes normally with a single result (0,0).
- start pulsed during FEED/UNLOAD -> ignored; dims of the running job unchanged.
